// File: rtl/serial_rx_pkg.sv
// Shared definitions for the parametrised serial receiver: state encoding,
// parity-sense constants and the frame-length helper.
package serial_rx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_DATA     = 3'd1;
    localparam state_t ST_PARITY   = 3'd2;
    localparam state_t ST_STOP     = 3'd3;
    localparam state_t ST_DONE     = 3'd4;
    localparam state_t ST_PERR     = 3'd5;
    localparam state_t ST_ERR_WAIT = 3'd6;

    // Parity sense selectors for the PARITY_ODD parameter.
    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    // Line bits per frame: start + data + optional parity + stop bits.
    function automatic int frame_len(input int dataBits, input int parityEn, input int stopBits);
        return 1 + dataBits + parityEn + stopBits;
    endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Data shift register (LSB received first) plus running XOR of the shifted-in bits.
module serial_rx_shifter
    import serial_rx_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 shiftEn_i,
    input  logic                 clear_i,
    input  logic                 bit_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 acc_o
);

    logic [DATA_BITS-1:0] sr_q;
    logic                 acc_q;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            acc_q <= 1'b0;
        end else if (clear_i) begin
            sr_q  <= '0;
            acc_q <= 1'b0;
        end else if (shiftEn_i) begin
            sr_q  <= {bit_i, sr_q[DATA_BITS-1:1]};
            acc_q <= acc_q ^ bit_i;
        end
    end

    assign data_o = sr_q;
    assign acc_o  = acc_q;

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised one-bit-per-clock serial receiver: deframes start / data / parity / stop,
// reports accepted words, parity errors and framing errors.
module serial_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = serial_rx_pkg::PAR_EVEN,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out_byte,
    output logic                 done,
    output logic                 parity_err,
    output logic                 framing_err,
    output logic                 busy
);

    import serial_rx_pkg::*;

    localparam int             CW        = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0]  STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic           ODD_BIT   = (PARITY_ODD == PAR_ODD);

    state_t               state_q, state_d;
    logic [CW-1:0]        bitCnt_q, bitCnt_d;
    logic                 mismatch_q, mismatch_d;
    logic [DATA_BITS-1:0] outByte_q;
    logic [DATA_BITS-1:0] srData;
    logic                 accBit;
    logic                 enterData, enterStop;

    // Counter and parity state are cleared whenever a new DATA or STOP phase begins.
    assign enterData = (state_d == ST_DATA) && (state_q != ST_DATA);
    assign enterStop = (state_d == ST_STOP) && (state_q != ST_STOP);

    serial_rx_shifter #(
        .DATA_BITS (DATA_BITS)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .shiftEn_i (state_q == ST_DATA),
        .clear_i   (enterData),
        .bit_i     (in),
        .data_o    (srData),
        .acc_o     (accBit)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; DONE and PERR accept a start bit just like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_PERR: state_d = in ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (bitCnt_q == DATA_LAST) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
                if (!in)                        state_d = ST_ERR_WAIT;
                else if (bitCnt_q == STOP_LAST) state_d = mismatch_q ? ST_PERR : ST_DONE;
            end
            ST_ERR_WAIT: begin
                if (in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shared bit counter (saturates at its terminal count) and parity mismatch flag.
    always_comb begin
        bitCnt_d   = bitCnt_q;
        mismatch_d = mismatch_q;
        if (enterData || enterStop) begin
            bitCnt_d = '0;
        end else if ((state_q == ST_DATA && bitCnt_q != DATA_LAST) ||
                     (state_q == ST_STOP && bitCnt_q != STOP_LAST)) begin
            bitCnt_d = bitCnt_q + CW'(1);
        end
        if (enterData) begin
            mismatch_d = 1'b0;
        end else if (state_q == ST_PARITY) begin
            mismatch_d = accBit ^ in ^ ODD_BIT;
        end
    end

    // Datapath registers; the output word only changes on the edge that accepts a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitCnt_q   <= '0;
            mismatch_q <= 1'b0;
            outByte_q  <= '0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            mismatch_q <= mismatch_d;
            if (state_d == ST_DONE) outByte_q <= srData;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        done        = (state_q == ST_DONE);
        parity_err  = (state_q == ST_PERR);
        framing_err = (state_q == ST_ERR_WAIT);
        busy        = (state_q == ST_DATA) || (state_q == ST_PARITY) || (state_q == ST_STOP);
    end

    assign out_byte = outByte_q;

endmodule

// File: tb/tb_serial_rx_param.sv
// Self-checking bench for serial_rx_param: four parameterisations driven with
// directed and random frames, checked against a frame-level reference model.
module tb_serial_rx_param;

    import serial_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       lineIn [4];
    logic [7:0] outA, outB, outC;
    logic [4:0] outD;
    logic       doneV  [4];
    logic       perrV  [4];
    logic       ferrV  [4];
    logic       busyV  [4];

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] expOut [4];

    // Instance configurations: A = 8N1, B = 8E1, C = 8N2, D = 5N1.
    int cfgBits [4] = '{8, 8, 8, 5};
    int cfgPar  [4] = '{0, 1, 0, 0};
    int cfgOdd  [4] = '{0, 0, 0, 0};
    int cfgStop [4] = '{1, 1, 2, 1};

    always #5 clk = ~clk;

    serial_rx_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutA (
        .clk(clk), .reset(reset), .in(lineIn[0]), .out_byte(outA), .done(doneV[0]),
        .parity_err(perrV[0]), .framing_err(ferrV[0]), .busy(busyV[0]));
    serial_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dutB (
        .clk(clk), .reset(reset), .in(lineIn[1]), .out_byte(outB), .done(doneV[1]),
        .parity_err(perrV[1]), .framing_err(ferrV[1]), .busy(busyV[1]));
    serial_rx_param #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dutC (
        .clk(clk), .reset(reset), .in(lineIn[2]), .out_byte(outC), .done(doneV[2]),
        .parity_err(perrV[2]), .framing_err(ferrV[2]), .busy(busyV[2]));
    serial_rx_param #(.DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dutD (
        .clk(clk), .reset(reset), .in(lineIn[3]), .out_byte(outD), .done(doneV[3]),
        .parity_err(perrV[3]), .framing_err(ferrV[3]), .busy(busyV[3]));

    function automatic logic [15:0] getOut(input int inst);
        case (inst)
            0:       return 16'(outA);
            1:       return 16'(outB);
            2:       return 16'(outC);
            default: return 16'(outD);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input int inst, input string tag, input logic eDone,
                              input logic ePerr, input logic eFerr, input logic eBusy);
        checkOutput($sformatf("%s[%0d].done", tag, inst), 16'(doneV[inst]), 16'(eDone));
        checkOutput($sformatf("%s[%0d].parity_err", tag, inst), 16'(perrV[inst]), 16'(ePerr));
        checkOutput($sformatf("%s[%0d].framing_err", tag, inst), 16'(ferrV[inst]), 16'(eFerr));
        checkOutput($sformatf("%s[%0d].busy", tag, inst), 16'(busyV[inst]), 16'(eBusy));
        checkOutput($sformatf("%s[%0d].out_byte", tag, inst), getOut(inst), expOut[inst]);
    endtask

    task automatic idleLine(input int inst, input int n);
        lineIn[inst] = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkFlags(inst, "idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // kind: 0 = good frame, 1 = wrong parity bit, 2 = last stop bit low.
    task automatic applyStimulus(input int inst, input logic [15:0] data, input int kind);
        logic        bits [$];
        int          nb;
        int          nFrame;
        int          ones;
        logic [15:0] d;
        logic        p;
        nb     = cfgBits[inst];
        nFrame = frame_len(cfgBits[inst], cfgPar[inst], cfgStop[inst]);
        d      = data & 16'((32'd1 << nb) - 1);
        ones   = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (cfgPar[inst] != 0) begin
            p = 1'((ones + cfgOdd[inst]) % 2);
            if (kind == 1) p = ~p;
            bits.push_back(p);
        end
        for (int s = 0; s < cfgStop[inst]; s++)
            bits.push_back((kind == 2 && s == cfgStop[inst] - 1) ? 1'b0 : 1'b1);
        for (int i = 0; i < nFrame; i++) begin
            lineIn[inst] = bits[i];
            @(posedge clk);
            @(negedge clk);
            if (i < nFrame - 1) checkFlags(inst, "mid", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        if (kind == 0) begin
            expOut[inst] = d;
            checkFlags(inst, "accept", 1'b1, 1'b0, 1'b0, 1'b0);
        end else if (kind == 1) begin
            checkFlags(inst, "perr", 1'b0, 1'b1, 1'b0, 1'b0);
        end else begin
            checkFlags(inst, "ferr", 1'b0, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 2; i++) begin
                @(posedge clk);
                @(negedge clk);
                checkFlags(inst, "ferrHold", 1'b0, 1'b0, 1'b1, 1'b0);
            end
            lineIn[inst] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checkFlags(inst, "ferrRelease", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [15:0] rdata;
        int          kind;
        logic [7:0]  pattern;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lineIn[i] = 1'b1;
            expOut[i] = 16'h0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) checkFlags(i, "reset", 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // 8N1 basic frame, then a back-to-back frame starting in the DONE cycle.
        applyStimulus(0, 16'h2A, 0);
        applyStimulus(0, 16'hFF, 0);
        idleLine(0, 2);

        // Even parity: good parity bit, then a wrong one that must not update out_byte.
        applyStimulus(1, 16'h07, 0);
        idleLine(1, 1);
        applyStimulus(1, 16'h07, 1);
        idleLine(1, 1);
        applyStimulus(1, 16'hC3, 1);
        idleLine(1, 1);

        // Two stop bits with the second one low, then a good frame.
        applyStimulus(2, 16'h33, 2);
        applyStimulus(2, 16'h5A, 0);
        idleLine(2, 1);

        // Five data bits.
        applyStimulus(3, 16'h13, 0);
        idleLine(3, 1);

        // Asynchronous reset in the middle of a data phase.
        pattern = 8'hA5;
        lineIn[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            lineIn[0] = pattern[i];
            @(posedge clk);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            expOut[i] = 16'h0;
            checkFlags(i, "asyncReset", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        lineIn[0] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(0, 16'hA5, 0);
        idleLine(0, 1);

        // Random frames per instance, including back-to-back and error frames.
        for (int inst = 0; inst < 4; inst++) begin
            for (int n = 0; n < 6; n++) begin
                rdata = 16'($urandom);
                kind  = int'($urandom_range(0, 2));
                if (kind == 1 && cfgPar[inst] == 0) kind = 0;
                applyStimulus(inst, rdata, kind);
                idleLine(inst, int'($urandom_range(0, 2)));
            end
            idleLine(inst, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
